// File: rtl/camera_csr_mz_if.sv
// camera_csr_mz_if: AHB-lite slave bus bundle for the camera CSR block.
interface camera_csr_mz_if;
    logic        sHSEL;
    logic        sHWrite;
    logic        sHREADY;
    logic [1:0]  sHTRANS;
    logic [31:0] sHADDR;
    logic [31:0] sHWDATA;
    logic        sHREADY_RESP;
    logic [1:0]  sHRESP;
    logic [31:0] sHRDATA;
    modport slave (
        input  sHSEL, sHWrite, sHREADY, sHTRANS, sHADDR, sHWDATA,
        output sHREADY_RESP, sHRESP, sHRDATA
    );
    modport master (
        output sHSEL, sHWrite, sHREADY, sHTRANS, sHADDR, sHWDATA,
        input  sHREADY_RESP, sHRESP, sHRDATA
    );
endinterface

// File: rtl/camera_csr_mz.sv
// camera_csr_mz: AHB-lite CSR block for a camera capture path.
// Holds zone base addresses, sticky status/interrupts, capture FSM and frame counter.
module camera_csr_mz #(
    parameter int N_ZONE   = 3,
    parameter int CNT_W    = 4,
    parameter int RQTH_RST = 5,
    parameter int FCNT_W   = 16
) (
    input  logic                   HCLK,
    input  logic                   HReset_N,
    camera_csr_mz_if.slave         bus,
    output logic                   Interrupt,
    output logic [32*N_ZONE-1:0]   BASE_ADDR,
    output logic [N_ZONE-1:0]      DATAOK,
    input  logic [N_ZONE-1:0]      DATAOK_Set,
    input  logic                   RQOverFlow,
    input  logic [CNT_W-1:0]       RQCNT,
    input  logic [2:0]             CurrentZone,
    input  logic [1:0]             ProtocolErr,
    input  logic                   FrameEnd,
    output logic                   HrefCtrl,
    output logic                   VsyncCtrl,
    output logic                   CaptureEn
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;

    localparam logic [12:0] SMASK = {5'h1f, 8'((1 << N_ZONE) - 1)};

    state_t              state_q, state_d;
    logic                wr_pend_q, wr_pend_d;
    logic [9:0]          wr_addr_q, wr_addr_d;
    logic                rd_stall_q, rd_stall_d;
    logic [9:0]          rd_addr_q, rd_addr_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         base_q [N_ZONE];
    logic [31:0]         base_d [N_ZONE];
    logic [CNT_W-1:0]    rqth_q, rqth_d;
    logic [12:0]         status_q, status_d;
    logic [12:0]         inten_q, inten_d;
    logic                cap_q, cap_d, vsync_q, vsync_d, href_q, href_d, grace_q, grace_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    logic                acc, stall_start, run;
    logic [9:0]          ra;
    logic [31:0]         rmux;
    logic [31:0]         wd;
    logic                we_rqth, we_st, we_ie, we_gcr, we_fc;
    logic [12:0]         set;
    logic [FCNT_W-1:0]   fc_base;
    logic                unused_bits;

    assign unused_bits = ^{bus.sHADDR[31:12], bus.sHADDR[1:0], bus.sHTRANS[0]};

    assign acc         = bus.sHSEL & bus.sHREADY & bus.sHTRANS[1];
    assign stall_start = acc & ~bus.sHWrite & wr_pend_q;
    assign run         = state_q != IDLE;
    assign wd          = bus.sHWDATA;
    assign we_rqth     = wr_pend_q && wr_addr_q == 10'h011;
    assign we_st       = wr_pend_q && wr_addr_q == 10'h012;
    assign we_ie       = wr_pend_q && wr_addr_q == 10'h013;
    assign we_gcr      = wr_pend_q && wr_addr_q == 10'h014;
    assign we_fc       = wr_pend_q && wr_addr_q == 10'h015;

    // A stalled read is re-evaluated once the pending write has landed
    assign ra = rd_stall_q ? rd_addr_q : bus.sHADDR[11:2];

    always_comb begin
        rmux = '0;
        for (int i = 0; i < N_ZONE; i++)
            if (ra == 10'(i)) rmux = base_q[i];
        case (ra)
            10'h010: rmux = 32'(RQCNT);
            10'h011: rmux = 32'(rqth_q);
            10'h012: rmux = {13'd0, CurrentZone, 3'd0, status_q};
            10'h013: rmux = 32'(inten_q);
            10'h014: rmux = {28'd0, cap_q, vsync_q, href_q, grace_q};
            10'h015: rmux = 32'(fcnt_q);
            10'h016: rmux = {30'd0, state_q};
            default: ;
        endcase
    end

    always_comb begin
        wr_pend_d  = acc & bus.sHWrite;
        wr_addr_d  = (acc & bus.sHWrite) ? bus.sHADDR[11:2] : wr_addr_q;
        rd_stall_d = stall_start;
        rd_addr_d  = stall_start ? bus.sHADDR[11:2] : rd_addr_q;
        ready_d    = ~stall_start;
        rdata_d    = ((acc & ~bus.sHWrite & ~wr_pend_q) | rd_stall_q) ? rmux : rdata_q;
    end

    always_comb begin
        base_d = base_q;
        for (int i = 0; i < N_ZONE; i++)
            if (wr_pend_q && wr_addr_q == 10'(i)) base_d[i] = wd;
        rqth_d = we_rqth ? wd[CNT_W-1:0] : rqth_q;
        set = '0;
        for (int i = 0; i < N_ZONE; i++) set[i] = DATAOK_Set[i];
        set[8]  = RQCNT >= rqth_q;
        set[9]  = RQOverFlow;
        set[10] = ProtocolErr[0];
        set[11] = ProtocolErr[1];
        set[12] = FrameEnd & run;
        status_d = ((status_q & ~(we_st ? wd[12:0] : 13'd0)) | set) & SMASK;
        inten_d  = we_ie ? wd[12:0] & SMASK : inten_q;
        cap_d    = we_gcr ? wd[0] : cap_q;
        grace_d  = we_gcr ? wd[3] : grace_q;
        vsync_d  = (we_gcr && state_q == IDLE) ? wd[1] : vsync_q;
        href_d   = (we_gcr && state_q == IDLE) ? wd[2] : href_q;
        // Clear then count, so a frame ending during the clearing write leaves 1
        fc_base = we_fc ? '0 : fcnt_q;
        fcnt_d  = (FrameEnd && run && !(&fc_base)) ? fc_base + FCNT_W'(1) : fc_base;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (we_gcr && wd[0]) state_d = RUN;
            RUN:      if (we_gcr && !wd[0]) state_d = wd[3] ? STOPPING : IDLE;
            STOPPING: if (we_gcr) state_d = wd[0] ? RUN : (wd[3] ? STOPPING : IDLE);
                      else if (FrameEnd) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HReset_N)
        if (!HReset_N) state_q <= IDLE;
        else state_q <= state_d;

    always_ff @(posedge HCLK or negedge HReset_N) begin
        if (!HReset_N) begin
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_stall_q <= 1'b0;
            rd_addr_q  <= '0;
            ready_q    <= 1'b1;
            rdata_q    <= '0;
            base_q     <= '{default: '0};
            rqth_q     <= CNT_W'(RQTH_RST);
            status_q   <= '0;
            inten_q    <= '0;
            cap_q      <= 1'b0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            grace_q    <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            rd_stall_q <= rd_stall_d;
            rd_addr_q  <= rd_addr_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            base_q     <= base_d;
            rqth_q     <= rqth_d;
            status_q   <= status_d;
            inten_q    <= inten_d;
            cap_q      <= cap_d;
            vsync_q    <= vsync_d;
            href_q     <= href_d;
            grace_q    <= grace_d;
            fcnt_q     <= fcnt_d;
        end
    end

    for (genvar i = 0; i < N_ZONE; i++) begin : g_base
        assign BASE_ADDR[32*i +: 32] = base_q[i];
    end

    assign DATAOK           = status_q[N_ZONE-1:0];
    assign Interrupt        = |(inten_q & status_q);
    assign VsyncCtrl        = vsync_q;
    assign HrefCtrl         = href_q;
    assign CaptureEn        = run;
    assign bus.sHREADY_RESP = ready_q;
    assign bus.sHRESP       = 2'b00;
    assign bus.sHRDATA      = rdata_q;
endmodule

// File: tb/tb_camera_csr_mz.sv
// tb_camera_csr_mz: directed scoreboard bench; reads queue expectations, a negedge monitor checks them.
module tb_camera_csr_mz;
    logic        HCLK = 0;
    logic        HReset_N;
    logic [95:0] BASE_ADDR;
    logic [2:0]  DATAOK, DATAOK_Set;
    logic        Interrupt, RQOverFlow, FrameEnd, HrefCtrl, VsyncCtrl, CaptureEn;
    logic [3:0]  RQCNT;
    logic [2:0]  CurrentZone;
    logic [1:0]  ProtocolErr;
    logic [95:0] base2;
    logic [2:0]  dok2;
    logic        irq2, href2, vsync2, cap2;

    camera_csr_mz_if m ();
    camera_csr_mz_if m2 ();

    assign m.sHREADY  = m.sHREADY_RESP;
    assign m2.sHREADY = m2.sHREADY_RESP;
    assign m2.sHSEL   = m.sHSEL;
    assign m2.sHWrite = m.sHWrite;
    assign m2.sHTRANS = m.sHTRANS;
    assign m2.sHADDR  = m.sHADDR;
    assign m2.sHWDATA = m.sHWDATA;

    camera_csr_mz u1 (
        .HCLK(HCLK), .HReset_N(HReset_N), .bus(m), .Interrupt(Interrupt), .BASE_ADDR(BASE_ADDR),
        .DATAOK(DATAOK), .DATAOK_Set(DATAOK_Set), .RQOverFlow(RQOverFlow), .RQCNT(RQCNT),
        .CurrentZone(CurrentZone), .ProtocolErr(ProtocolErr), .FrameEnd(FrameEnd),
        .HrefCtrl(HrefCtrl), .VsyncCtrl(VsyncCtrl), .CaptureEn(CaptureEn)
    );

    camera_csr_mz #(.FCNT_W(2)) u2 (
        .HCLK(HCLK), .HReset_N(HReset_N), .bus(m2), .Interrupt(irq2), .BASE_ADDR(base2),
        .DATAOK(dok2), .DATAOK_Set(DATAOK_Set), .RQOverFlow(RQOverFlow), .RQCNT(RQCNT),
        .CurrentZone(CurrentZone), .ProtocolErr(ProtocolErr), .FrameEnd(FrameEnd),
        .HrefCtrl(href2), .VsyncCtrl(vsync2), .CaptureEn(cap2)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       n;
        logic [31:0] e;
        int          w;
        bit          c2;
        logic [31:0] e2;
    } exp_t;

    exp_t        q[$];
    exp_t        x;
    int          total = 0;
    int          bad = 0;
    bit          rd_ph = 0;
    int          waits = 0;
    logic [31:0] pend = 0;

    task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(input bit w, input logic [31:0] a);
        int n = 0;
        @(posedge HCLK); #1;
        while (!m.sHREADY_RESP && n < 8) begin
            @(posedge HCLK); #1;
            n++;
        end
        if (n == 8) chk("bus_ready_timeout", 96'(m.sHREADY_RESP), 96'd1);
        m.sHWDATA = pend;
        m.sHSEL   = 1;
        m.sHTRANS = 2'b10;
        m.sHWrite = w;
        m.sHADDR  = a;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1, a);
        pend = d;
    endtask

    task automatic rd(input string n, input logic [31:0] a, input logic [31:0] e, input int w,
                      input bit c2 = 0, input logic [31:0] e2 = 0);
        exp_t t;
        drive(0, a);
        pend = 0;
        t.n = n; t.e = e; t.w = w; t.c2 = c2; t.e2 = e2;
        q.push_back(t);
    endtask

    task automatic idle(input logic [2:0] ds, input bit fe);
        @(posedge HCLK); #1;
        m.sHWDATA  = pend;
        pend       = 0;
        m.sHSEL    = 0;
        m.sHTRANS  = 2'b00;
        DATAOK_Set = ds;
        FrameEnd   = fe;
        @(posedge HCLK); #1;
        DATAOK_Set = 0;
        FrameEnd   = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge HCLK); #1;
            n++;
        end
        if (n == 50) chk("drain_timeout", 96'(q.size()), 96'd0);
    endtask

    always @(negedge HCLK) begin
        if (!HReset_N) rd_ph = 0;
        else begin
            if (rd_ph) begin
                if (!m.sHREADY_RESP) waits++;
                else begin
                    rd_ph = 0;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_read: got %h", m.sHRDATA);
                    end else begin
                        x = q.pop_front();
                        total++;
                        if (m.sHRDATA !== x.e) begin
                            bad++;
                            $display("FAIL %s: rdata %h want %h", x.n, m.sHRDATA, x.e);
                        end
                        total++;
                        if (waits != x.w) begin
                            bad++;
                            $display("FAIL %s_wait: waits %0d want %0d", x.n, waits, x.w);
                        end
                        if (x.c2) begin
                            total++;
                            if (m2.sHRDATA !== x.e2) begin
                                bad++;
                                $display("FAIL %s_fcw2: rdata %h want %h", x.n, m2.sHRDATA, x.e2);
                            end
                        end
                    end
                end
            end
            if (m.sHSEL && m.sHREADY && m.sHTRANS[1] && !m.sHWrite) begin
                rd_ph = 1;
                waits = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        HReset_N = 0;
        m.sHSEL = 0; m.sHWrite = 0; m.sHTRANS = 0; m.sHADDR = 0; m.sHWDATA = 0;
        DATAOK_Set = 0; RQOverFlow = 0; RQCNT = 0; CurrentZone = 0; ProtocolErr = 0; FrameEnd = 0;
        repeat (3) @(posedge HCLK);
        #1 HReset_N = 1;
        chk("rst_ready", 96'(m.sHREADY_RESP), 96'd1);
        chk("rst_rdata", 96'(m.sHRDATA), 96'd0);
        chk("rst_base", BASE_ADDR, 96'd0);
        chk("rst_outs", 96'({Interrupt, CaptureEn, VsyncCtrl, HrefCtrl, DATAOK}), 96'd0);
        rd("rst_rqth", 32'h044, 32'd5, 0);
        rd("rst_status", 32'h048, 32'd0, 0);
        rd("rst_gcr", 32'h050, 32'd0, 0);

        wr(32'h008, 32'h1234_5678);
        idle(0, 0);
        chk("base2_out", 96'(BASE_ADDR[95:64]), 96'h1234_5678);
        chk("base01_out", 96'(BASE_ADDR[63:0]), 96'd0);
        rd("base2_rd", 32'h008, 32'h1234_5678, 0);
        rd("base2_hiaddr", 32'h1000_0008, 32'h1234_5678, 0);
        rd("zone3_none", 32'h00C, 32'd0, 0);

        wr(32'h044, 32'h1A);
        rd("rqth_stall", 32'h044, 32'hA, 1);
        wr(32'h05C, 32'hFFFF);
        rd("unmapped_stall", 32'h05C, 32'd0, 1);

        wr(32'h04C, 32'h001);
        idle(3'b001, 0);
        chk("dataok0", 96'(DATAOK), 96'd1);
        chk("irq_on", 96'(Interrupt), 96'd1);
        rd("status_dok0", 32'h048, 32'h1, 0);
        wr(32'h048, 32'h1);
        idle(3'b001, 0);
        chk("w1c_set_wins", 96'(DATAOK), 96'd1);
        wr(32'h048, 32'h1);
        idle(0, 0);
        chk("w1c_clear", 96'(DATAOK), 96'd0);
        chk("irq_off", 96'(Interrupt), 96'd0);
        idle(3'b100, 0);
        chk("dataok2_irq", 96'({Interrupt, DATAOK}), 96'h4);
        rd("status_dok2", 32'h048, 32'h4, 0);

        wr(32'h050, 32'h9);
        idle(0, 0);
        chk("run_capen", 96'(CaptureEn), 96'd1);
        rd("cap_run", 32'h058, 32'd1, 0);
        rd("gcr_9", 32'h050, 32'h9, 0);
        wr(32'h050, 32'h8);
        idle(0, 0);
        chk("stop_capen", 96'(CaptureEn), 96'd1);
        rd("cap_stopping", 32'h058, 32'd2, 0);
        idle(0, 1);
        chk("idle_capen", 96'(CaptureEn), 96'd0);
        rd("cap_idle", 32'h058, 32'd0, 0);
        rd("fcnt_1", 32'h054, 32'd1, 0, 1, 32'd1);
        rd("status_fdone", 32'h048, 32'h1004, 0);
        rd("gcr_graceful", 32'h050, 32'h1, 0);
        wr(32'h048, 32'h1FFF);
        idle(0, 0);

        wr(32'h050, 32'h1);
        wr(32'h050, 32'h3);
        idle(0, 0);
        chk("vsync_locked", 96'({VsyncCtrl, CaptureEn}), 96'h1);
        rd("gcr_run", 32'h050, 32'h8, 0);
        repeat (5) idle(0, 1);
        rd("fcnt_6_sat3", 32'h054, 32'd6, 0, 1, 32'd3);
        wr(32'h050, 32'h8);
        wr(32'h050, 32'h1);
        idle(0, 1);
        rd("stop_to_run", 32'h058, 32'd1, 0);
        rd("fcnt_7", 32'h054, 32'd7, 0, 1, 32'd3);
        wr(32'h054, 32'h0);
        idle(0, 1);
        rd("fcnt_clr_inc", 32'h054, 32'd1, 0, 1, 32'd1);
        wr(32'h050, 32'h0);
        idle(0, 0);
        chk("abort_capen", 96'(CaptureEn), 96'd0);
        idle(0, 1);
        rd("fcnt_idle_hold", 32'h054, 32'd1, 0, 1, 32'd1);
        wr(32'h050, 32'h6);
        idle(0, 0);
        chk("vsync_href_idle", 96'({VsyncCtrl, HrefCtrl}), 96'h3);
        rd("gcr_6", 32'h050, 32'h6, 0);
        wr(32'h050, 32'h1);
        idle(0, 0);
        chk("run_before_rst", 96'(CaptureEn), 96'd1);
        drain();

        wr(32'h000, 32'hDEAD_BEEF);
        @(posedge HCLK); #1;
        HReset_N  = 0;
        m.sHSEL   = 0;
        m.sHTRANS = 0;
        m.sHWDATA = pend;
        pend      = 0;
        repeat (2) @(posedge HCLK);
        #1 HReset_N = 1;
        chk("rst2_base", BASE_ADDR, 96'd0);
        chk("rst2_outs", 96'({Interrupt, CaptureEn, VsyncCtrl, HrefCtrl, DATAOK}), 96'd0);
        chk("rst2_ready", 96'(m.sHREADY_RESP), 96'd1);
        rd("rst2_rqth", 32'h044, 32'd5, 0);
        rd("rst2_gcr", 32'h050, 32'd0, 0);
        rd("rst2_fcnt", 32'h054, 32'd0, 0, 1, 32'd0);
        rd("rst2_cap", 32'h058, 32'd0, 0);
        rd("rst2_inten", 32'h04C, 32'd0, 0);
        rd("rst2_base0", 32'h000, 32'd0, 0);

        @(posedge HCLK); #1;
        m.sHSEL = 0; m.sHTRANS = 0;
        RQCNT = 4'd5; CurrentZone = 3'd5; RQOverFlow = 1; ProtocolErr = 2'b11;
        @(posedge HCLK); #1;
        RQOverFlow = 0; ProtocolErr = 2'b00;
        chk("rq_irq_masked", 96'(Interrupt), 96'd0);
        rd("status_hw", 32'h048, 32'h0005_0F00, 0);
        rd("rqcnt_rd", 32'h040, 32'd5, 0);
        wr(32'h04C, 32'h100);
        idle(0, 0);
        chk("rq_irq_on", 96'(Interrupt), 96'd1);
        drain();
        repeat (3) @(posedge HCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/camera_csr_mz.md
CAMERA_CSR_MZ -- requirements
Module: camera_csr_mz

Interface
REQ-001 SHALL have parameter N_ZONE, default 3: number of frame-buffer zones, legal 1..8.
REQ-002 SHALL have parameter CNT_W, default 4: width of RQCNT and RQTH.
REQ-003 SHALL have parameter RQTH_RST, default 5: reset value of RQTH.
REQ-004 SHALL have parameter FCNT_W, default 16: frame counter width, legal 1..32.
REQ-005 SHALL have port HCLK, input, 1: clock; all state on rising edge.
REQ-006 SHALL have port HReset_N, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports sHSEL/sHWrite/sHREADY, input, 1 each: AHB slave select, write, bus ready.
REQ-008 SHALL have ports sHTRANS (2), sHADDR (32), sHWDATA (32), input: AHB slave; sHADDR[11:2] decoded, rest ignored.
REQ-009 SHALL have ports sHREADY_RESP (1), sHRESP (2), sHRDATA (32), output: AHB slave response.
REQ-010 SHALL have port Interrupt, output, 1: level interrupt.
REQ-011 SHALL have port BASE_ADDR, output, 32*N_ZONE: zone i base at bits [32i+31:32i].
REQ-012 SHALL have ports DATAOK (output) and DATAOK_Set (input), N_ZONE each: zone-done status and set pulses.
REQ-013 SHALL have inputs RQOverFlow (1), RQCNT (CNT_W), CurrentZone (3), ProtocolErr (2), FrameEnd (1, one-cycle end-of-frame pulse).
REQ-014 SHALL have outputs HrefCtrl, VsyncCtrl, CaptureEn, 1 each.

Function
REQ-015 SHALL accept a transfer when sHSEL & sHREADY & sHTRANS[1]; sHRESP always 2'b00.
REQ-016 SHALL register write address at address phase; register updates from sHWDATA in the following (data-phase) cycle.
REQ-017 SHALL register read data at address phase, giving zero wait states, except REQ-018.
REQ-018 SHALL, when a read is accepted while a write data phase is pending, drive sHREADY_RESP=0 for exactly one cycle, then return post-write register contents with sHREADY_RESP=1.
REQ-019 SHALL map registers: 0x000+4i BASE_ADDR zone i (RW, i<N_ZONE); 0x040 RQCNT (RO); 0x044 RQTH (RW, CNT_W LSBs); 0x048 STATUS; 0x04C INTEN (RW, same bit layout as STATUS); 0x050 GCR; 0x054 FRAMECNT; 0x058 CAPSTATE (RO, bits[1:0]); other offsets read 0, writes ignored.
REQ-020 SHALL lay out STATUS as: [7:0] DATAOK per zone (bits >= N_ZONE read 0); [8] RQTH_HIT; [9] OVF; [10] PERR0; [11] PERR1; [12] FRAME_DONE; [18:16] CurrentZone (RO); others 0.
REQ-021 SHALL set STATUS bits on DATAOK_Set[i], RQCNT>=RQTH, RQOverFlow, ProtocolErr[0], ProtocolErr[1], FrameEnd (RUN/STOPPING only) respectively; write-1 clears; set wins over simultaneous clear.
REQ-022 SHALL drive Interrupt = OR of (INTEN & STATUS[12:0]), combinational from registers.
REQ-023 SHALL implement GCR: [0] CAP_REQ, [1] VSYNC, [2] HREF, [3] GRACEFUL; reads return {CAP_REQ, VSYNC, HREF, GRACEFUL}; VSYNC/HREF writes take effect only in IDLE.
REQ-024 SHALL implement capture FSM IDLE(0)/RUN(1)/STOPPING(2); CaptureEn=1 in RUN and STOPPING.
REQ-025 SHALL transition IDLE->RUN on GCR write with bit0=1; RUN->STOPPING on bit0=0 with GRACEFUL=1 (GRACEFUL value in same write); RUN->IDLE on bit0=0 with GRACEFUL=0.
REQ-026 SHALL transition STOPPING->IDLE on FrameEnd; STOPPING->RUN on GCR write bit0=1; write priority over same-cycle FrameEnd.
REQ-027 SHALL increment FRAMECNT on FrameEnd in RUN/STOPPING, saturating at all-ones; any FRAMECNT write clears to 0; increment wins over same-cycle clear (result 1).
REQ-028 SHALL drive HrefCtrl/VsyncCtrl from GCR[2]/GCR[1].

Reset
REQ-029 SHALL on HReset_N low, asynchronously: BASE_ADDR=0, RQTH=RQTH_RST, STATUS=0, INTEN=0, GCR=0, FRAMECNT=0, FSM=IDLE, sHRDATA=0, sHREADY_RESP=1, all outputs 0; reset mid-transfer abandons it.

Verification
REQ-030 Write 0x1234_5678 to 0x008 (N_ZONE=3), read -> BASE_ADDR[95:64]=0x12345678, readback equal, no wait state.
REQ-031 Write 0x044, immediately read 0x044 -> one cycle sHREADY_RESP=0, then new value returned.
REQ-032 INTEN=0x001, DATAOK_Set[0] pulse -> STATUS[0]=1, Interrupt=1; W1C 0x1 concurrent with another Set -> bit stays 1.
REQ-033 GCR=0x9 (RUN, graceful), write 0x8 -> CAPSTATE=2, CaptureEn=1; FrameEnd -> IDLE, CaptureEn=0, FRAMECNT=1, STATUS[12]=1.
REQ-034 In RUN write GCR VSYNC=1 -> VsyncCtrl stays 0; FCNT_W=2 with 5 FrameEnd pulses -> FRAMECNT=3.
REQ-035 RQCNT=5, RQTH reset -> STATUS[8]=1 next cycle; assert HReset_N low mid-operation -> all registers at reset values.
